// File: rtl/capture_sink_pkg.sv
// Shared definitions for the capture sink and the source-side blocks that
// talk to it.
//   state_e       : 2-bit capture FSM encoding (IDLE, SKIP, CAPTURE, DONE)
//   MODE_ONESHOT  : stop when the buffer is full
//   MODE_WRAP     : keep capturing circularly until stop_sink
package capture_sink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam int MODE_ONESHOT = 0;
    localparam int MODE_WRAP    = 1;

endpackage : capture_sink_pkg

// File: rtl/sink_dpram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Read-during-write to the same address returns the old word. Written so a
// vendor RAM macro can replace it without touching the capture logic.
//   clk_i      : clock
//   reset_i    : synchronous active-high, clears only the read register
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_addr_i  : read address (sampled every cycle)
//   rd_data_o  : RAM word at rd_addr_i, one cycle later
module sink_dpram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    // Only the low address bits needed for DEPTH index the array.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [2**IDX_W];
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign wr_idx = wr_addr_i[IDX_W-1:0];
    assign rd_idx = rd_addr_i[IDX_W-1:0];

    generate
        if (IDX_W < ADDR_W) begin : g_upper
            logic unused_addr_bits;
            assign unused_addr_bits = ^{wr_addr_i[ADDR_W-1:IDX_W], rd_addr_i[ADDR_W-1:IDX_W]};
        end
    endgenerate

    // NOTE: the array has no reset; clearing it would prevent RAM inference,
    // and captured data must survive a reset anyway.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx] <= wr_data_i;
        end
    end

    // NOTE: non-blocking assignment samples mem_q before this edge's write
    // lands, which is what gives old-data read-during-write behaviour.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= mem_q[rd_idx];
        end
    end

endmodule : sink_dpram

// File: rtl/capture_sink.sv
// Capture sink: arms on start_sink, drops SKIP leading valid samples, then
// stores start_write-qualified words into RAM at an incrementing address.
// One-shot mode stops when DEPTH words are written; wrap mode overwrites the
// oldest word and runs until stop_sink.
//   clk, reset            : clock, synchronous active-high reset
//   start_sink/stop_sink  : 1-cycle arm / stop pulses
//   start_write, data_in  : sample valid strobe and sample
//   rd_addr, rd_data      : independent read-back port, 1-cycle latency
//   wr_addr, count        : next write address, words written (saturating)
//   busy, full, done      : SKIP/CAPTURE, DEPTH reached (sticky), DONE
//   overflow              : sticky, write attempted while DONE (one-shot)
module capture_sink
    import capture_sink_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 16,
    parameter int SKIP      = 2,
    parameter int WRAP_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_sink,
    input  logic              stop_sink,
    input  logic              start_write,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              done,
    output logic              overflow
);

    localparam int SKIP_W = (SKIP < 1) ? 1 : $clog2(SKIP + 1);
    localparam logic [SKIP_W-1:0] SKIP_LAST  = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [ADDR_W-1:0] DEPTH_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT  = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic              full_q, full_d;
    logic              overflow_q, overflow_d;
    logic              busy_q, done_q;
    logic              wren;

    // NOTE: every variable gets its default before the case, so no branch
    // can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        count_d    = count_q;
        skip_cnt_d = skip_cnt_q;
        full_d     = full_q;
        overflow_d = overflow_q;
        wren       = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // Arming takes priority over a coincident stop or write.
                if (start_sink) begin
                    state_d    = (SKIP == 0) ? ST_CAPTURE : ST_SKIP;
                    wr_addr_d  = '0;
                    count_d    = '0;
                    skip_cnt_d = '0;
                    full_d     = 1'b0;
                    overflow_d = 1'b0;
                end else if (state_q == ST_DONE && start_write && WRAP_MODE == MODE_ONESHOT) begin
                    overflow_d = 1'b1;
                end
            end

            ST_SKIP: begin
                if (stop_sink) begin
                    state_d = ST_DONE;
                end else if (start_write) begin
                    skip_cnt_d = skip_cnt_q + 1'b1;
                    if (skip_cnt_q == SKIP_LAST) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end

            ST_CAPTURE: begin
                if (start_write) begin
                    wren = 1'b1;
                    if (count_q != DEPTH_CNT) begin
                        count_d = count_q + 1'b1;
                    end
                    if (wr_addr_q == DEPTH_LAST) begin
                        full_d = 1'b1;
                        if (WRAP_MODE == MODE_WRAP) begin
                            wr_addr_d = '0;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
                // A write in the stop cycle has already been taken above.
                if (stop_sink) begin
                    state_d = ST_DONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_addr_q  <= '0;
            count_q    <= '0;
            skip_cnt_q <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            count_q    <= count_d;
            skip_cnt_q <= skip_cnt_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            // Status flags are registered from the next state so they are
            // flop outputs aligned with state_q.
            busy_q     <= (state_d == ST_SKIP) || (state_d == ST_CAPTURE);
            done_q     <= (state_d == ST_DONE);
        end
    end

    sink_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i     (clk),
        .reset_i   (reset),
        .wr_en_i   (wren),
        .wr_addr_i (wr_addr_q),
        .wr_data_i (data_in),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign wr_addr  = wr_addr_q;
    assign count    = count_q;
    assign busy     = busy_q;
    assign full     = full_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule : capture_sink

// File: tb/tb_capture_sink.sv
// Bench for capture_sink: instance 0 is one-shot with SKIP=2, instance 1 is
// wrap mode with SKIP=0, both DEPTH=16. A transaction-level model predicts
// every output; a negedge process compares each cycle, and literal checks
// pin the model at the key points of each scenario.
module tb_capture_sink;

    localparam int DEPTH = 16;
    localparam int P_SKIP [2] = '{2, 0};
    localparam int P_WRAP [2] = '{0, 1};

    logic       clk = 1'b0;
    logic [1:0] rst_v, start_v, stop_v, we_v;
    logic [7:0] din_v   [2];
    logic [7:0] raddr_v [2];
    logic [7:0] rd_o    [2];
    logic [7:0] wa_o    [2];
    logic [8:0] cnt_o   [2];
    logic [1:0] busy_o, full_o, done_o, ovf_o;

    int  total = 0;
    int  bad   = 0;
    bit  cmp_en = 1'b0;

    always #5 clk = ~clk;

    capture_sink #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .SKIP(2), .WRAP_MODE(0)) u_a (
        .clk(clk), .reset(rst_v[0]), .start_sink(start_v[0]), .stop_sink(stop_v[0]),
        .start_write(we_v[0]), .data_in(din_v[0]), .rd_addr(raddr_v[0]), .rd_data(rd_o[0]),
        .wr_addr(wa_o[0]), .count(cnt_o[0]), .busy(busy_o[0]), .full(full_o[0]),
        .done(done_o[0]), .overflow(ovf_o[0])
    );

    capture_sink #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .SKIP(0), .WRAP_MODE(1)) u_b (
        .clk(clk), .reset(rst_v[1]), .start_sink(start_v[1]), .stop_sink(stop_v[1]),
        .start_write(we_v[1]), .data_in(din_v[1]), .rd_addr(raddr_v[1]), .rd_data(rd_o[1]),
        .wr_addr(wa_o[1]), .count(cnt_o[1]), .busy(busy_o[1]), .full(full_o[1]),
        .done(done_o[1]), .overflow(ovf_o[1])
    );

    // ---------------- model ----------------
    bit         m_active [2];
    bit         m_done   [2];
    int         m_skip_left [2];
    int         m_wr  [2];
    int         m_cnt [2];
    bit         m_full [2];
    bit         m_ovf  [2];
    logic [7:0] m_mem   [2][DEPTH];
    bit         m_known [2][DEPTH];
    logic [7:0] m_rd    [2];
    bit         m_rd_known [2];

    task automatic model_step(input int k);
        int         ra;
        logic [7:0] nrd;
        bit         nknown;
        if (rst_v[k]) begin
            m_active[k] = 0; m_done[k] = 0; m_skip_left[k] = 0;
            m_wr[k] = 0; m_cnt[k] = 0; m_full[k] = 0; m_ovf[k] = 0;
            m_rd[k] = 8'h00; m_rd_known[k] = 1;
        end else begin
            ra     = int'(raddr_v[k]) % DEPTH;
            nrd    = m_mem[k][ra];
            nknown = m_known[k][ra];
            if (!m_active[k] && start_v[k]) begin
                m_active[k] = 1; m_done[k] = 0; m_skip_left[k] = P_SKIP[k];
                m_wr[k] = 0; m_cnt[k] = 0; m_full[k] = 0; m_ovf[k] = 0;
            end else if (m_active[k] && m_skip_left[k] > 0) begin
                if (stop_v[k]) begin
                    m_active[k] = 0; m_done[k] = 1;
                end else if (we_v[k]) begin
                    m_skip_left[k]--;
                end
            end else if (m_active[k]) begin
                if (we_v[k]) begin
                    m_mem[k][m_wr[k]]   = din_v[k];
                    m_known[k][m_wr[k]] = 1;
                    if (m_cnt[k] < DEPTH) m_cnt[k]++;
                    if (m_wr[k] == DEPTH - 1) begin
                        m_full[k] = 1;
                        if (P_WRAP[k] == 1) m_wr[k] = 0;
                        else begin m_active[k] = 0; m_done[k] = 1; end
                    end else begin
                        m_wr[k]++;
                    end
                end
                if (stop_v[k]) begin
                    m_active[k] = 0; m_done[k] = 1;
                end
            end else if (m_done[k] && we_v[k] && P_WRAP[k] == 0) begin
                m_ovf[k] = 1;
            end
            m_rd[k]       = nrd;
            m_rd_known[k] = nknown;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("u%0d.busy", k),     32'(busy_o[k]), 32'(m_active[k]));
                check($sformatf("u%0d.done", k),     32'(done_o[k]), 32'(m_done[k]));
                check($sformatf("u%0d.full", k),     32'(full_o[k]), 32'(m_full[k]));
                check($sformatf("u%0d.overflow", k), 32'(ovf_o[k]),  32'(m_ovf[k]));
                check($sformatf("u%0d.count", k),    32'(cnt_o[k]),  32'(m_cnt[k]));
                check($sformatf("u%0d.wr_addr", k),  32'(wa_o[k]),   32'(m_wr[k]));
                if (m_rd_known[k])
                    check($sformatf("u%0d.rd_data", k), 32'(rd_o[k]), 32'(m_rd[k]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int k, input bit st, input bit sp, input bit w, input logic [7:0] d);
        start_v[k] = st; stop_v[k] = sp; we_v[k] = w; din_v[k] = d;
        cyc();
        start_v[k] = 1'b0; stop_v[k] = 1'b0; we_v[k] = 1'b0; din_v[k] = 8'h00;
    endtask

    task automatic read_check(input int k, input int addr, input logic [7:0] exp);
        raddr_v[k] = 8'(addr);
        cyc();
        check($sformatf("u%0d.RAM[%0d]", k, addr), 32'(rd_o[k]), 32'(exp));
    endtask

    task automatic flags_check(input int k, input string tag, input int b, input int f,
                               input int dn, input int ov, input int cnt, input int wa);
        check({tag, ".busy"},     32'(busy_o[k]), 32'(b));
        check({tag, ".full"},     32'(full_o[k]), 32'(f));
        check({tag, ".done"},     32'(done_o[k]), 32'(dn));
        check({tag, ".overflow"}, 32'(ovf_o[k]),  32'(ov));
        check({tag, ".count"},    32'(cnt_o[k]),  32'(cnt));
        check({tag, ".wr_addr"},  32'(wa_o[k]),   32'(wa));
    endtask

    initial begin
        rst_v = 2'b11; start_v = '0; stop_v = '0; we_v = '0;
        for (int k = 0; k < 2; k++) begin
            din_v[k] = 8'h00; raddr_v[k] = 8'h00;
        end
        cyc();
        cyc();
        cmp_en = 1'b1;
        rst_v = 2'b00;

        // Reset state
        flags_check(0, "reset", 0, 0, 0, 0, 0, 0);
        check("reset.rd_data", 32'(rd_o[0]), 32'h00);

        // Test 1: one-shot, two samples dropped, 16 stored
        pulse(0, 1, 0, 0, 8'h00);
        for (int i = 0; i <= 8'h11; i++) pulse(0, 0, 0, 1, 8'(i));
        flags_check(0, "t1", 0, 1, 1, 0, 16, 15);
        for (int i = 0; i < DEPTH; i++) read_check(0, i, 8'(i + 2));

        // Test 2: write while DONE sets overflow, RAM untouched
        pulse(0, 0, 0, 1, 8'hAA);
        check("t2.overflow", 32'(ovf_o[0]), 32'd1);
        read_check(0, 15, 8'h11);

        // Test 6: stop together with write #7 stores that word
        pulse(0, 1, 0, 0, 8'h00);
        pulse(0, 0, 0, 1, 8'hF0);
        pulse(0, 0, 0, 1, 8'hF1);
        for (int i = 0; i < 7; i++) pulse(0, 0, (i == 6), 1, 8'(8'h40 + i));
        flags_check(0, "t6", 0, 0, 1, 0, 7, 7);
        raddr_v[0] = 8'd6;
        cyc();
        check("t6.rd_data", 32'(rd_o[0]), 32'h46);
        read_check(0, 7, 8'h09);

        // Test 4: reset mid-capture after 5 writes, RAM survives
        pulse(0, 1, 0, 0, 8'h00);
        pulse(0, 0, 0, 1, 8'hF0);
        pulse(0, 0, 0, 1, 8'hF1);
        for (int i = 0; i < 5; i++) pulse(0, 0, 0, 1, 8'(8'h60 + i));
        rst_v[0] = 1'b1;
        cyc();
        rst_v[0] = 1'b0;
        flags_check(0, "t4", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) read_check(0, i, 8'(8'h60 + i));

        // Stop during SKIP: DONE with nothing written
        pulse(0, 1, 0, 0, 8'h00);
        pulse(0, 0, 0, 1, 8'hF0);
        pulse(0, 0, 1, 0, 8'h00);
        flags_check(0, "skipstop", 0, 0, 1, 0, 0, 0);

        // Test 5: start+stop together in DONE re-arms, then gapped valids;
        // a start pulse mid-capture is ignored
        pulse(0, 1, 1, 0, 8'h00);
        check("t5.rearm_busy", 32'(busy_o[0]), 32'd1);
        for (int i = 0; i <= 8'h11; i++) begin
            pulse(0, 0, 0, 1, 8'(i));
            pulse(0, (i == 5), 0, 0, 8'h00);
            pulse(0, 0, 0, 0, 8'h00);
        end
        flags_check(0, "t5", 0, 1, 1, 0, 16, 15);
        for (int i = 0; i < DEPTH; i++) read_check(0, i, 8'(i + 2));

        // Test 3: wrap mode, 20 writes then stop
        pulse(1, 1, 0, 0, 8'h00);
        check("t3.busy_armed", 32'(busy_o[1]), 32'd1);
        for (int i = 0; i < 20; i++) pulse(1, 0, 0, 1, 8'(i));
        check("t3.busy_running", 32'(busy_o[1]), 32'd1);
        pulse(1, 0, 1, 0, 8'h00);
        flags_check(1, "t3", 0, 1, 1, 0, 16, 4);
        for (int i = 0; i < 4; i++) read_check(1, i, 8'(8'h10 + i));
        read_check(1, 4, 8'h04);
        pulse(1, 0, 0, 1, 8'hBB);
        check("t3.no_overflow_wrap", 32'(ovf_o[1]), 32'd0);

        cyc();
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_capture_sink
